// File: rtl/mux_registrado_n.sv
// Registered N-way word selector with valid/ready flow control.
// One of N_ENTRADAS words is picked by a sparse selector code from the
// CODIGOS table; the result is registered and handed downstream through
// a two-entry skid buffer (output register + skid register).
// Unknown codes reuse the last legal selection and flag erro_seletor.
//
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   entradas           - N_ENTRADAS packed words, word i at [i*LARGURA +: LARGURA]
//   seletor            - selector code, sampled with the accepted beat
//   valido_entrada     - input beat valid
//   pronto_entrada     - block can accept a beat (registered)
//   saida              - selected word (registered)
//   erro_seletor       - current output beat came from an illegal code
//   valido_saida       - output beat valid (registered)
//   pronto_saida       - downstream accepts
module mux_registrado_n #(
  parameter int unsigned LARGURA    = 32,
  parameter int unsigned N_ENTRADAS = 6,
  parameter int unsigned SEL_W      = 4,
  parameter logic [N_ENTRADAS*SEL_W-1:0] CODIGOS =
    {4'b1100, 4'b0111, 4'b0110, 4'b0010, 4'b0001, 4'b0000}
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_ENTRADAS*LARGURA-1:0] entradas,
  input  logic [SEL_W-1:0]              seletor,
  input  logic                          valido_entrada,
  output logic                          pronto_entrada,
  output logic [LARGURA-1:0]            saida,
  output logic                          erro_seletor,
  output logic                          valido_saida,
  input  logic                          pronto_saida
);

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    CHEIO = 2'd1,
    SKID  = 2'd2
  } estado_t;

  estado_t              estado;
  estado_t              estado_prox_c;
  logic [LARGURA-1:0]   ultimo;
  logic [LARGURA-1:0]   sk_dado;
  logic                 sk_erro;

  logic                 acerto_c;
  logic [LARGURA-1:0]   palavra_c;
  logic [LARGURA-1:0]   dado_dec_c;
  logic                 erro_dec_c;
  logic                 entra_c;
  logic                 sai_c;

  // Table lookup: scan from the top so the lowest matching index wins.
  always_comb begin
    acerto_c  = 1'b0;
    palavra_c = '0;
    for (int i = int'(N_ENTRADAS) - 1; i >= 0; i--) begin
      if (seletor == CODIGOS[i*SEL_W +: SEL_W]) begin
        acerto_c  = 1'b1;
        palavra_c = entradas[i*LARGURA +: LARGURA];
      end
    end
    dado_dec_c = acerto_c ? palavra_c : ultimo;
    erro_dec_c = ~acerto_c;
  end

  assign entra_c = valido_entrada & pronto_entrada;
  assign sai_c   = valido_saida & pronto_saida;

  // Occupancy transitions of the two-entry buffer.
  always_comb begin
    estado_prox_c = estado;
    case (estado)
      VAZIO:   if (entra_c) estado_prox_c = CHEIO;
      CHEIO: begin
        if (entra_c && !sai_c)      estado_prox_c = SKID;
        else if (!entra_c && sai_c) estado_prox_c = VAZIO;
      end
      SKID:    if (sai_c) estado_prox_c = CHEIO;
      default: estado_prox_c = VAZIO;
    endcase
  end

  // State, storage and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= VAZIO;
      saida          <= '0;
      erro_seletor   <= 1'b0;
      valido_saida   <= 1'b0;
      pronto_entrada <= 1'b1;
      ultimo         <= '0;
      sk_dado        <= '0;
      sk_erro        <= 1'b0;
    end else begin
      estado         <= estado_prox_c;
      pronto_entrada <= (estado_prox_c != SKID);
      valido_saida   <= (estado_prox_c != VAZIO);

      if (entra_c && acerto_c) ultimo <= palavra_c;

      case (estado)
        VAZIO: begin
          if (entra_c) begin
            saida        <= dado_dec_c;
            erro_seletor <= erro_dec_c;
          end
        end
        CHEIO: begin
          if (entra_c && sai_c) begin
            saida        <= dado_dec_c;
            erro_seletor <= erro_dec_c;
          end else if (entra_c) begin
            sk_dado <= dado_dec_c;
            sk_erro <= erro_dec_c;
          end
        end
        SKID: begin
          // pronto_entrada is low here, so only the drain can happen.
          if (sai_c) begin
            saida        <= sk_dado;
            erro_seletor <= sk_erro;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_registrado_n.sv
// Randomized and directed bench for mux_registrado_n against a queue-based
// reference model; a second small instance covers a duplicate code table.
module tb_mux_registrado_n;

  localparam int unsigned L  = 32;
  localparam int unsigned N  = 6;
  localparam int unsigned SW = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic [N*L-1:0]     entradas;
  logic [SW-1:0]      seletor;
  logic               valido_entrada;
  logic               pronto_entrada;
  logic [L-1:0]       saida;
  logic               erro_seletor;
  logic               valido_saida;
  logic               pronto_saida;

  logic [23:0]        entradas2;
  logic [1:0]         seletor2;
  logic               valido_entrada2;
  logic               pronto_entrada2;
  logic [7:0]         saida2;
  logic               erro_seletor2;
  logic               valido_saida2;
  logic               pronto_saida2;

  always #5 clock = ~clock;

  mux_registrado_n dut (
    .clock(clock), .reset(reset), .entradas(entradas), .seletor(seletor),
    .valido_entrada(valido_entrada), .pronto_entrada(pronto_entrada),
    .saida(saida), .erro_seletor(erro_seletor), .valido_saida(valido_saida),
    .pronto_saida(pronto_saida)
  );

  mux_registrado_n #(
    .LARGURA(8), .N_ENTRADAS(3), .SEL_W(2), .CODIGOS({2'b01, 2'b01, 2'b00})
  ) dut2 (
    .clock(clock), .reset(reset), .entradas(entradas2), .seletor(seletor2),
    .valido_entrada(valido_entrada2), .pronto_entrada(pronto_entrada2),
    .saida(saida2), .erro_seletor(erro_seletor2), .valido_saida(valido_saida2),
    .pronto_saida(pronto_saida2)
  );

  // Reference model: the code table, last legal word and in-flight beats.
  logic [3:0]  tabela [N] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
  logic [31:0] ult_mod;
  logic [32:0] fila [$];

  int vetores = 0;
  int erros   = 0;

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    vetores++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, esp, $time);
    end
  endtask

  task automatic confere();
    verifica("valido_saida", 64'(valido_saida), 64'(fila.size() != 0));
    verifica("pronto_entrada", 64'(pronto_entrada), 64'(fila.size() < 2));
    if (fila.size() != 0) begin
      verifica("saida", 64'(saida), 64'(fila[0][31:0]));
      verifica("erro_seletor", 64'(erro_seletor), 64'(fila[0][32]));
    end
  endtask

  // One clock: predict handshakes from the model, step, then compare.
  task automatic ciclo(output bit aceito);
    bit          sai;
    bit          achou;
    logic [32:0] item;
    aceito = valido_entrada && (fila.size() < 2);
    sai    = (fila.size() != 0) && pronto_saida;
    item   = '0;
    if (aceito) begin
      achou = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        if (!achou && tabela[i] == seletor) begin
          achou   = 1'b1;
          ult_mod = entradas[i*L +: L];
        end
      end
      item = {~achou, ult_mod};
    end
    @(posedge clock); #1;
    if (sai) void'(fila.pop_front());
    if (aceito) fila.push_back(item);
    confere();
  endtask

  task automatic reinicia();
    reset = 1'b1;
    valido_entrada = 1'b0;
    valido_entrada2 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    fila.delete();
    ult_mod = '0;
    verifica("rst_saida", 64'(saida), 64'd0);
    verifica("rst_erro", 64'(erro_seletor), 64'd0);
    confere();
  endtask

  task automatic palavras_padrao();
    for (int i = 0; i < int'(N); i++) entradas[i*L +: L] = 32'h11111111 * 32'(i + 1);
  endtask

  initial begin
    bit ac;
    reset = 1'b0;
    entradas = '0;
    seletor = '0;
    valido_entrada = 1'b0;
    pronto_saida = 1'b1;
    entradas2 = '0;
    seletor2 = '0;
    valido_entrada2 = 1'b0;
    pronto_saida2 = 1'b1;
    ult_mod = '0;
    @(negedge clock);
    reinicia();

    // Default table sweep at full throughput.
    palavras_padrao();
    for (int i = 0; i < int'(N); i++) begin
      seletor = tabela[i];
      valido_entrada = 1'b1;
      ciclo(ac);
      verifica("sweep_word", 64'(saida), 64'(32'h11111111 * 32'(i + 1)));
    end
    valido_entrada = 1'b0;
    ciclo(ac);

    // Illegal code repeats the last legal word; next legal beat clears it.
    entradas[2*L +: L] = 32'hAAAA0000;
    valido_entrada = 1'b1;
    seletor = 4'b0010; ciclo(ac);
    seletor = 4'b1111; ciclo(ac);
    verifica("ilegal_saida", 64'(saida), 64'h0000_0000_AAAA_0000);
    verifica("ilegal_erro", 64'(erro_seletor), 64'd1);
    seletor = 4'b0000; ciclo(ac);
    verifica("legal_limpa", 64'(erro_seletor), 64'd0);
    valido_entrada = 1'b0;
    ciclo(ac);

    // Illegal code as the first beat after reset.
    reinicia();
    palavras_padrao();
    valido_entrada = 1'b1;
    seletor = 4'b0101; ciclo(ac);
    verifica("pos_rst_saida", 64'(saida), 64'd0);
    verifica("pos_rst_erro", 64'(erro_seletor), 64'd1);
    valido_entrada = 1'b0;
    ciclo(ac);

    // Backpressure: A and B fill the buffer, C waits until release.
    pronto_saida = 1'b0;
    valido_entrada = 1'b1;
    seletor = 4'h0; ciclo(ac); verifica("bp_aceita_a", 64'(ac), 64'd1);
    seletor = 4'h1; ciclo(ac); verifica("bp_aceita_b", 64'(ac), 64'd1);
    verifica("bp_pronto_baixo", 64'(pronto_entrada), 64'd0);
    seletor = 4'h2;
    for (int k = 0; k < 3; k++) ciclo(ac);
    verifica("bp_saida_estavel", 64'(saida), 64'h11111111);
    pronto_saida = 1'b1;
    ac = 1'b0;
    for (int k = 0; k < 10 && !ac; k++) ciclo(ac);
    verifica("bp_aceita_c", 64'(ac), 64'd1);
    valido_entrada = 1'b0;
    for (int k = 0; k < 4; k++) ciclo(ac);

    // Reset while both registers are full.
    pronto_saida = 1'b0;
    valido_entrada = 1'b1;
    seletor = 4'h6; ciclo(ac);
    seletor = 4'h7; ciclo(ac);
    verifica("skid_cheio", 64'(pronto_entrada), 64'd0);
    reinicia();
    pronto_saida = 1'b1;
    for (int k = 0; k < 3; k++) ciclo(ac);

    // Duplicate table on the small instance: lowest matching index wins.
    entradas2 = 24'h332211;
    valido_entrada2 = 1'b1;
    seletor2 = 2'b01;
    @(posedge clock); #1;
    verifica("dup_saida", 64'(saida2), 64'h22);
    verifica("dup_erro", 64'(erro_seletor2), 64'd0);
    verifica("dup_valido", 64'(valido_saida2), 64'd1);
    seletor2 = 2'b11;
    @(posedge clock); #1;
    verifica("dup_ilegal_saida", 64'(saida2), 64'h22);
    verifica("dup_ilegal_erro", 64'(erro_seletor2), 64'd1);
    seletor2 = 2'b00;
    @(posedge clock); #1;
    verifica("dup_idx0", 64'(saida2), 64'h11);
    valido_entrada2 = 1'b0;
    @(posedge clock); #1;
    verifica("dup_dreno", 64'(valido_saida2), 64'd0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < int'(N); i++) entradas[i*L +: L] = $urandom;
      seletor = 4'($urandom);
      valido_entrada = 1'($urandom_range(0, 3) != 0);
      pronto_saida = 1'($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) reinicia();
      else ciclo(ac);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/mux_registrado_n.md
# mux_registrado_n

Parametrised, registered N-way word selector with valid/ready flow control, replacing fixed combinational datapath muxes. It selects one of N input words by a sparse selector code from a configurable code table, registers the result, and passes it downstream through a two-entry skid buffer. Selector codes outside the table never infer latches: they return the last legal selection and raise an error flag. It sits between the control decode stage and the ALU/write-back operand path.

## Interface

**Parameters**
- `LARGURA`, 32, data word width.
- `N_ENTRADAS`, 6, number of input words, 2..16.
- `SEL_W`, 4, selector width.
- `CODIGOS`, `{4'b1100, 4'b0111, 4'b0110, 4'b0010, 4'b0001, 4'b0000}`, packed code table. Entry i is `CODIGOS[i*SEL_W +: SEL_W]` and selects input word i.

**Ports**
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `entradas` in N_ENTRADAS*LARGURA: word i is `entradas[i*LARGURA +: LARGURA]`.
- `seletor` in SEL_W: selector code, sampled with the beat.
- `valido_entrada` in 1: input beat valid.
- `pronto_entrada` out 1: block can accept a beat; driven from a register.
- `saida` out LARGURA: selected word.
- `erro_seletor` out 1: the current output beat came from an illegal code.
- `valido_saida` out 1: output beat valid.
- `pronto_saida` in 1: downstream accepts.

## Operation

**Handshakes**
- Input transfer occurs when `valido_entrada && pronto_entrada` at a rising edge.
- Output transfer occurs when `valido_saida && pronto_saida` at a rising edge.

**Decode (combinational, on the accepted beat)**
- Compare `seletor` against every table entry.
- If several entries match, the lowest index wins.
- Match: data = word i, err = 0. Update the `ultimo` register (reset 0) to word i.
- No match: data = `ultimo`, err = 1. `ultimo` does not change.

**Storage**
- Output register (OR) drives `saida` and `erro_seletor`.
- A skid register (SK) has the same width plus the err bit.

**State machine**
- VAZIO (OR empty):
  - Input transfer loads OR → CHEIO.
- CHEIO (OR full, SK empty):
  - Input and output transfer together: OR reloads → CHEIO.
  - Output transfer only → VAZIO.
  - Input transfer only: beat goes to SK → SKID.
  - Neither → CHEIO.
- SKID (both full, `pronto_entrada`=0):
  - Output transfer: SK moves to OR → CHEIO.
  - Otherwise stays in SKID.
- `pronto_entrada` is registered as (next_state != SKID).
- `valido_saida` = (state != VAZIO).

**Data rules**
- While `valido_saida`=1 and `pronto_saida`=0, `saida` and `erro_seletor` are stable.
- Beats leave in strict acceptance order.
- No beat is dropped or duplicated.
- `entradas` and `seletor` are don't-care when no input transfer occurs.

**Reset**
- Takes effect at the first rising edge with `reset`=1, and has priority over all handshakes.
- State → VAZIO.
- `saida`=0, `erro_seletor`=0, `valido_saida`=0, `pronto_entrada`=1.
- `ultimo`=0; SK is cleared.
- A reset mid-stream discards beats held in OR and SK.

## Timing

- Latency: a beat accepted at edge k appears on `saida` with `valido_saida`=1 after edge k, when OR was empty or draining.
- Throughput: 1 beat per cycle while `pronto_saida`=1.
- No combinational path from `pronto_saida` to `pronto_entrada`.
- No combinational path from `entradas`/`seletor` to any output.
- Backpressure: `pronto_entrada` falls the cycle after SK fills.
  - With `pronto_saida` held low, at most 2 beats are accepted.
- `pronto_entrada` rises the cycle after an output transfer from SKID.
- Simultaneous input and output transfer in CHEIO: occupancy is unchanged and OR takes the new beat.

## Test plan

1. **Default table sweep.** Drive words 0x11111111 × (i+1) and codes 0000, 0001, 0010, 0110, 0111, 1100, with `pronto_saida`=1.
   → `saida` = 0x11111111, 0x22222222, … 0x66666666, one per cycle, each one cycle after acceptance, `erro_seletor`=0.
2. **Illegal code.** Legal code 0010 (word 0xAAAA0000), then code 1111.
   → Second beat `saida`=0xAAAA0000 with `erro_seletor`=1; next legal beat clears the flag.
3. **Illegal code right after reset.** Code 0101 as the first beat.
   → `saida`=0x00000000, `erro_seletor`=1.
4. **Backpressure.** Hold `pronto_saida`=0 and stream beats A, B, C.
   → A, B accepted; `pronto_entrada`=0 from the cycle after B; C held.
   → Release `pronto_saida`: output order A, B, C with no gaps or loss.
5. **Reset in SKID.** Reset with both registers full.
   → Next cycle `valido_saida`=0, `saida`=0, `pronto_entrada`=1; the flushed beats never appear.
6. **Duplicate and parametrised table.** `N_ENTRADAS`=3, `LARGURA`=8, `CODIGOS`={2'b01, 2'b01, 2'b00}, code 01.
   → Selects word 1, the lowest matching index.
